// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: opcodes, FSM states and
// the acceptance-time precondition check.
package stack_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC1,
    ST_EXEC2,
    ST_EXEC3,
    ST_EXEC4
  } state_e;

  // True when the operation can run against the current stack occupancy.
  // Codes 6 and 7 have no meaning and are always rejected.
  function automatic logic op_legal(input logic [OP_W-1:0] code,
                                    input logic has_one,
                                    input logic has_two,
                                    input logic is_full);
    logic ok;
    ok = 1'b0;
    case (code)
      OP_NOP:  ok = 1'b1;
      OP_PUSH: ok = !is_full;
      OP_POP:  ok = has_one;
      OP_DUP:  ok = has_one && !is_full;
      OP_SWAP: ok = has_two;
      OP_OVER: ok = has_two && !is_full;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Requester-side bundle of the stack controller: operation handshake plus
// the status view of the stack (top word, occupancy, empty/full).
interface stack_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  import stack_pkg::*;

  localparam int DW = $clog2(DEPTH + 1);

  logic             op_valid;
  logic [OP_W-1:0]  op_code;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] tos;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;

  modport master (
    output op_valid, op_code, op_data,
    input  op_ready, done, err, tos, depth, empty, full
  );

  modport slave (
    input  op_valid, op_code, op_data,
    output op_ready, done, err, tos, depth, empty, full
  );

endinterface

// File: rtl/stack.sv
// Simple LIFO storage: one push or one pop per cycle, registered top word.
// The array itself is never reset; an occupancy of zero makes it empty.
module stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           insert,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] top_reg;
  logic [CW-1:0]    below;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  // After a pop the new top lives one slot below the old top.
  assign below   = count_reg - CW'(2);
  assign wr_addr = count_reg[AW-1:0];
  assign rd_addr = below[AW-1:0];

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_addr] <= insert;
    end
  end

  // Occupancy and registered top-of-stack, updated on the push/pop edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      top_reg   <= '0;
    end else if (push) begin
      count_reg <= count_reg + CW'(1);
      top_reg   <= insert;
    end else if (pop) begin
      count_reg <= count_reg - CW'(1);
      if (count_reg >= CW'(2)) begin
        top_reg <= mem[rd_addr];
      end
    end
  end

  assign top   = top_reg;
  assign count = count_reg;

endmodule

// File: rtl/stack_ctrl.sv
// Multi-cycle stack operation controller: accepts one op at a time, checks
// its preconditions up front, then sequences push/pop steps on the stack.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  stack_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e           state_reg, state_next;
  logic [OP_W-1:0]  code_reg, code_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             fail_reg, fail_next;
  logic             ready_reg, ready_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] insert;
  logic [WIDTH-1:0] tos_w;
  logic [CW-1:0]    depth_w;
  logic             full_w;
  logic             accept;
  logic             legal;
  logic             multi;

  stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .insert (insert),
    .top    (tos_w),
    .count  (depth_w)
  );

  assign full_w = (depth_w == CW'(DEPTH));
  assign accept = bus.op_valid && ready_reg;
  assign legal  = op_legal(bus.op_code, depth_w >= CW'(1), depth_w >= CW'(2), full_w);
  assign multi  = (bus.op_code == OP_SWAP) || (bus.op_code == OP_OVER);

  // Next-state, stack strobes and the registered done/err for the cycle ahead.
  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    data_next  = data_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    fail_next  = fail_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    insert     = data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          code_next  = bus.op_code;
          data_next  = bus.op_data;
          fail_next  = !legal;
          state_next = ST_EXEC1;
          // Rejected and single-step ops finish in EXEC1.
          done_next  = !legal || !multi;
          err_next   = !legal;
        end
      end
      ST_EXEC1: begin
        state_next = ST_IDLE;
        if (!fail_reg) begin
          case (op_e'(code_reg))
            OP_PUSH: begin
              push   = 1'b1;
              insert = data_reg;
            end
            OP_POP: pop = 1'b1;
            OP_DUP: begin
              push   = 1'b1;
              insert = tos_w;
            end
            OP_SWAP, OP_OVER: begin
              a_next     = tos_w;
              pop        = 1'b1;
              state_next = ST_EXEC2;
            end
            default: ;
          endcase
        end
      end
      ST_EXEC2: begin
        b_next     = tos_w;
        state_next = ST_EXEC3;
        if (code_reg == OP_OVER) begin
          push      = 1'b1;
          insert    = a_reg;
          done_next = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      ST_EXEC3: begin
        push = 1'b1;
        if (code_reg == OP_SWAP) begin
          insert     = a_reg;
          state_next = ST_EXEC4;
          done_next  = 1'b1;
        end else begin
          insert     = b_reg;
          state_next = ST_IDLE;
        end
      end
      ST_EXEC4: begin
        push       = 1'b1;
        insert     = b_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ready_next = (state_next == ST_IDLE);

  // State register; reset abandons any op in flight without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      code_reg  <= '0;
      data_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      fail_reg  <= 1'b0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      data_reg  <= data_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      fail_reg  <= fail_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign bus.op_ready = ready_reg;
  assign bus.done     = done_reg;
  assign bus.err      = err_reg;
  assign bus.tos      = tos_w;
  assign bus.depth    = depth_w;
  assign bus.empty    = (depth_w == '0);
  assign bus.full     = full_w;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 8, entry capacity of the internal stack (>= 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  requester presents an operation.
REQ-006 op_code  input  3  operation encoding (see Structure).
REQ-007 op_data  input  WIDTH  operand for PUSH; ignored otherwise.
REQ-008 op_ready  output  1  controller can accept an operation this cycle.
REQ-009 done  output  1  one-cycle pulse in the final execute cycle of an accepted operation.
REQ-010 err  output  1  one-cycle pulse, coincident with done, when the operation was rejected.
REQ-011 tos  output  WIDTH  current top-of-stack word, undefined when empty.
REQ-012 depth  output  $clog2(DEPTH+1)  number of valid entries.
REQ-013 empty / full  output  1 each  depth==0 / depth==DEPTH.

Function
REQ-014 The block SHALL accept an op on a rising edge where op_valid && op_ready, latching op_code and op_data.
REQ-015 op_ready SHALL be high only in state IDLE; low from the accept edge through the last execute cycle; high again the cycle after done.
REQ-016 FSM states SHALL be IDLE, EXEC1, EXEC2, EXEC3, EXEC4; accept moves IDLE->EXEC1; each op advances one state per cycle and returns to IDLE after its last step.
REQ-017 The block SHALL never assert internal push and pop in the same cycle.
REQ-018 NOP: EXEC1 only, no stack access, done pulses.
REQ-019 PUSH: EXEC1 drives push with insert=latched op_data; depth+1.
REQ-020 POP: EXEC1 drives pop; depth-1.
REQ-021 DUP: EXEC1 drives push with insert=tos; depth+1.
REQ-022 SWAP (4 cycles): EXEC1 capture a=tos, pop; EXEC2 capture b=tos, pop; EXEC3 push a; EXEC4 push b; net depth unchanged, top two entries exchanged.
REQ-023 OVER (3 cycles): EXEC1 capture a=tos, pop; EXEC2 capture b=tos, push a; EXEC3 push b; depth+1.
REQ-024 Preconditions checked at acceptance: PUSH needs !full; POP needs depth>=1; DUP needs depth>=1 and !full; SWAP needs depth>=2; OVER needs depth>=2 and !full; codes 6-7 always illegal.
REQ-025 A failing op SHALL take EXEC1 only, perform no stack access, leave depth unchanged, and pulse done and err together.
REQ-026 depth SHALL update on the same edge as the corresponding internal push/pop; tos and depth reflect the completed op in the cycle after done.
REQ-027 done and err SHALL be registered outputs, low in all cycles except as stated.

Reset
REQ-028 On reset_n low, asynchronously: state=IDLE, depth=0, empty=1, full=0, done=0, err=0, op_ready=0 while reset_n low, 1 from the first clock after release.
REQ-029 Reset during any EXEC state SHALL abandon the op with no done pulse; stack array contents are not cleared (depth=0 makes them logically empty).

Structure
REQ-030 Opcodes (NOP=0, PUSH=1, POP=2, DUP=3, SWAP=4, OVER=5) and the FSM state enum SHALL live in shared package stack_pkg.
REQ-031 The block SHALL instantiate the existing stack module (WIDTH, DEPTH passed through) as its only sub-module, driving push, pop, insert and reading top as tos.

Verification
REQ-032 Reset then PUSH 0..7 (DEPTH=8) -> each done 1 cycle after accept, depth 8, full=1, tos=7.
REQ-033 From full, PUSH 99 and DUP -> err+done pulse each, depth stays 8, tos stays 7.
REQ-034 Stack [..,5,7], SWAP -> done in 4th execute cycle, op_ready low 4 cycles, then tos=5, next entry 7, depth unchanged.
REQ-035 Stack [3,4] (depth 2), OVER -> tos=3, then POP sequence yields 3,4,3, depth 3->0, empty=1.
REQ-036 Empty stack, POP then SWAP then op_code 7 -> three err pulses, depth stays 0.
REQ-037 Assert reset_n low during EXEC2 of SWAP -> no done, depth=0, empty=1, op_ready=1 first clock after release.
